rs_age_select: RTL

//  Oldest-first issue selector for one reservation station. Tracks the relative age of

---
 rtl/rs_age_select.sv | 110 +++++++++++
 1 files changed

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - oldest-first issue selector for one reservation station
// Optional simulation checks: define RS_AGE_SELECT_ASSERT_EN.
module rs_age_select #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alloc_valid,
  input  logic [IDX_W-1:0]   alloc_idx,
  input  logic [ENTRIES-1:0] ready_mask,
  input  logic               issue_ready,
  output logic               issue_valid,
  output logic [IDX_W-1:0]   issue_idx,
  output logic [ENTRIES-1:0] entry_valid,
  output logic [IDX_W:0]     count,
  output logic               full,
  output logic               empty
);

  // age[i][j] = 1 means entry i was allocated before entry j
  logic [ENTRIES-1:0] age [ENTRIES];

  logic               fire;
  logic [ENTRIES-1:0] fire_mask;
  logic [ENTRIES-1:0] alloc_mask;
  logic [ENTRIES-1:0] live_after_free;
  logic [ENTRIES-1:0] elig;
  logic [ENTRIES-1:0] sel;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic               blocked;

  assign fire = issue_valid & issue_ready;

  always_comb begin
    fire_mask  = '0;
    alloc_mask = '0;
    if (fire)        fire_mask[issue_idx]  = 1'b1;
    if (alloc_valid) alloc_mask[alloc_idx] = 1'b1;
  end

  assign live_after_free = entry_valid & ~fire_mask;
  assign elig            = entry_valid & ready_mask & ~fire_mask;

  // An eligible entry wins when no other eligible entry is older than it.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    blocked = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < ENTRIES; j++) begin
        if (elig[j] && age[j][i]) blocked = 1'b1;
      end
      sel[i] = elig[i] & ~blocked;
      if (sel[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_any = |sel;
  assign full    = (count == (IDX_W+1)'(ENTRIES));
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      entry_valid <= '0;
      count       <= '0;
      issue_valid <= 1'b0;
      issue_idx   <= '0;
      for (int i = 0; i < ENTRIES; i++) age[i] <= '0;
    end else begin
      entry_valid <= live_after_free | alloc_mask;
      count       <= count + (IDX_W+1)'(alloc_valid) - (IDX_W+1)'(fire);
      if (alloc_valid) begin
        for (int i = 0; i < ENTRIES; i++) age[i][alloc_idx] <= live_after_free[i];
        age[alloc_idx] <= '0;
      end
      // A stalled grant holds; the held entry is never re-picked.
      if (!issue_valid || issue_ready) begin
        issue_valid <= sel_any;
        issue_idx   <= sel_idx;
      end
    end
  end

`ifdef RS_AGE_SELECT_ASSERT_EN
  logic             stalled_q;
  logic [IDX_W-1:0] stalled_idx_q;

  always_ff @(posedge clk) begin
    stalled_q     <= !rst && !flush && issue_valid && !issue_ready;
    stalled_idx_q <= issue_idx;
    if (!rst) begin
      assert (!(alloc_valid && live_after_free[alloc_idx]))
        else $error("rs_age_select: alloc to live non-firing entry %0d", alloc_idx);
      assert (!(alloc_valid && full && !fire))
        else $error("rs_age_select: alloc while full");
      assert (!stalled_q || (issue_valid && issue_idx == stalled_idx_q))
        else $error("rs_age_select: grant changed while stalled");
      assert (!issue_valid || entry_valid[issue_idx])
        else $error("rs_age_select: grant on non-live entry %0d", issue_idx);
      assert (count == (IDX_W+1)'($countones(entry_valid)))
        else $error("rs_age_select: count does not match live mask");
    end
  end
`endif

endmodule
